// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU encodings: control codes, alu_op classes and funct3 values.
// Used by the issue stage and by the ALU that consumes its entries.
package alu_issue_stage_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_DEPTH  = 2;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_NOT     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_JUMP    = 4'b1000;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] OP_LS  = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_RT  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_NOT     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID-to-issue and issue-to-EX signal bundle. The master side is the pipeline
// around the issue stage (ID producer plus EX consumer); the slave side is the stage.
interface alu_issue_stage_if #(
  parameter int DATA_W = 8
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic              alu_src;
  logic              is_itype;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [3:0]        ALU_control;
  logic              illegal;
  logic [7:0]        illegal_count;

  modport master (
    output flush, in_valid, alu_op, funct3, funct7b5, alu_src, is_itype,
           rs1_val, rs2_val, imm, out_ready,
    input  in_ready, out_valid, data1, data2, ALU_control, illegal, illegal_count
  );

  modport slave (
    input  flush, in_valid, alu_op, funct3, funct7b5, alu_src, is_itype,
           rs1_val, rs2_val, imm, out_ready,
    output in_ready, out_valid, data1, data2, ALU_control, illegal, illegal_count
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder: alu_op class plus function fields
// produce the 4-bit ALU code and an illegal-function flag.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_itype_i,
  output logic [3:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    alu_control_o = ALU_ILLEGAL;
    illegal_o     = 1'b0;
    unique case (alu_op_i)
      OP_LS:  alu_control_o = ALU_ADD;
      OP_BR:  alu_control_o = ALU_SUB;
      OP_JMP: alu_control_o = ALU_JUMP;
      OP_RT: begin
        case (funct3_i)
          // I-type ops reuse funct7 bits as immediate, so SUB needs R-type.
          F3_ADD_SUB: alu_control_o = (funct7b5_i && !is_itype_i) ? ALU_SUB : ALU_ADD;
          F3_AND:     alu_control_o = ALU_AND;
          F3_OR:      alu_control_o = ALU_OR;
          F3_XOR:     alu_control_o = ALU_XOR;
          F3_NOT:     alu_control_o = ALU_NOT;
          default: begin
            alu_control_o = ALU_ILLEGAL;
            illegal_o     = 1'b1;
          end
        endcase
      end
      default: alu_control_o = ALU_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue buffer between ID and the ALU: decodes and selects operands
// on entry, presents the head to EX, and counts accepted illegal entries.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [3:0]        ctrl;
    logic              illegal;
  } entry_t;

  localparam entry_t ENTRY_RST = '{data1: '0, data2: '0, ctrl: ALU_ILLEGAL, illegal: 1'b0};

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  entry_t     new_entry;
  entry_t     head;

  entry_t     entry_q [2];
  entry_t     hold_q, hold_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [7:0] ill_cnt_q, ill_cnt_d;
  logic       push, pop;

  alu_ctrl_decode u_decode (
    .alu_op_i      (bus.alu_op),
    .funct3_i      (bus.funct3),
    .funct7b5_i    (bus.funct7b5),
    .is_itype_i    (bus.is_itype),
    .alu_control_o (dec_ctrl),
    .illegal_o     (dec_illegal)
  );

  assign new_entry = '{data1:   bus.rs1_val,
                       data2:   bus.alu_src ? bus.imm : bus.rs2_val,
                       ctrl:    dec_ctrl,
                       illegal: dec_illegal};

  // in_ready comes from registered count only, so out_ready never reaches it.
  assign bus.in_ready  = (count_q < 2'd2);
  assign bus.out_valid = (count_q != 2'd0);
  assign push          = bus.in_valid  & bus.in_ready & ~bus.flush;
  assign pop           = bus.out_valid & bus.out_ready & ~bus.flush;

  // When empty, show the last presented head rather than a stale slot.
  assign head              = bus.out_valid ? entry_q[rd_ptr_q] : hold_q;
  assign bus.data1         = head.data1;
  assign bus.data2         = head.data2;
  assign bus.ALU_control   = head.ctrl;
  assign bus.illegal       = head.illegal;
  assign bus.illegal_count = ill_cnt_q;

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ill_cnt_d = ill_cnt_q;
    hold_d    = head;
    if (bus.flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push && dec_illegal && (ill_cnt_q != 8'hFF)) ill_cnt_d = ill_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      ill_cnt_q <= 8'd0;
      hold_q    <= ENTRY_RST;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ill_cnt_q <= ill_cnt_d;
      hold_q    <= hold_d;
    end
  end

  // NOTE: the entry array is reset on purpose; outputs must show defined reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= ENTRY_RST;
      entry_q[1] <= ENTRY_RST;
    end else if (push) begin
      entry_q[wr_ptr_q] <= new_entry;
    end
  end

endmodule
